// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through data cache controller.
//   2^INDEX_BITS lines x 4 words, one valid bit per line.
//   Address split: offset = addr[3:2], index = addr[INDEX_BITS+3:4],
//   tag = addr[31:INDEX_BITS+4].
//
// Ports
//   clock, reset             rising-edge clock, synchronous active-high reset
//   cpu_read, cpu_write      load/store request from MEM stage (both = store)
//   cpu_addr, cpu_wdata      byte address (bits [1:0] ignored), store data
//   cpu_rdata, cpu_stall     load data, pipeline freeze
//   mem_req, mem_we          backing-memory request, 1=write
//   mem_addr, mem_wdata      word-aligned address, write data
//   mem_rdata, mem_ready     read data, one-cycle completion pulse per word
//
// Optional feature macro: DCACHE_WRITE_ALLOCATE_EN
//   defined   : a write miss refills the line first, then performs the write
//   undefined : no-write-allocate, write misses leave the cache untouched
module dcache_ctrl #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, REFILL, RESPOND, WRITE} state_t;

  state_t                        state_q, state_d;
  logic [1:0]                    cnt_q, cnt_d;
  logic [31:2]                   addr_q, addr_d;
  logic [31:0]                   wdata_q, wdata_d;
  logic                          alloc_q, alloc_d;
  logic [LINES-1:0]              valid_q, valid_d;
  logic [LINES-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [LINES-1:0][3:0][31:0]   data_q, data_d;

  // Address decode for the live request (IDLE) and the latched one (busy states)
  logic [INDEX_BITS-1:0] c_idx, q_idx;
  logic [TAG_W-1:0]      c_tag, q_tag;
  logic [1:0]            c_off, q_off;
  logic                  c_hit, q_hit;

  assign c_idx = cpu_addr[INDEX_BITS+3:4];
  assign c_tag = cpu_addr[31:INDEX_BITS+4];
  assign c_off = cpu_addr[3:2];
  assign q_idx = addr_q[INDEX_BITS+3:4];
  assign q_tag = addr_q[31:INDEX_BITS+4];
  assign q_off = addr_q[3:2];
  assign c_hit = valid_q[c_idx] && (tag_q[c_idx] == c_tag);
  assign q_hit = valid_q[q_idx] && (tag_q[q_idx] == q_tag);

  // Byte-lane bits are not used by a word cache
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      alloc_q <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      alloc_q <= alloc_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data storage carry no reset; the valid bits guard them
  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  // Next-state and storage update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    alloc_d = alloc_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_write) begin
          addr_d  = cpu_addr[31:2];
          wdata_d = cpu_wdata;
          alloc_d = 1'b0;
          state_d = WRITE;
`ifdef DCACHE_WRITE_ALLOCATE_EN
          if (!c_hit) begin
            alloc_d          = 1'b1;
            cnt_d            = 2'd0;
            valid_d[c_idx]   = 1'b0;
            state_d          = REFILL;
          end
`endif
        end else if (cpu_read && !c_hit) begin
          addr_d         = cpu_addr[31:2];
          alloc_d        = 1'b0;
          cnt_d          = 2'd0;
          // Line is invalid while being overwritten so an aborted refill leaves nothing behind
          valid_d[c_idx] = 1'b0;
          state_d        = REFILL;
        end
      end
      REFILL: begin
        if (mem_ready) begin
          data_d[q_idx][cnt_q] = mem_rdata;
          cnt_d                = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            valid_d[q_idx] = 1'b1;
            tag_d[q_idx]   = q_tag;
            cnt_d          = 2'd0;
            state_d        = alloc_q ? WRITE : RESPOND;
          end
        end
      end
      RESPOND: state_d = IDLE;
      WRITE: begin
        if (mem_ready) begin
          if (q_hit) data_d[q_idx][q_off] = wdata_q;
          alloc_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_write) begin
          cpu_stall = 1'b1;
        end else if (cpu_read) begin
          if (c_hit) cpu_rdata = data_q[c_idx][c_off];
          else       cpu_stall = 1'b1;
        end
      end
      REFILL: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {addr_q[31:4], cnt_q, 2'b00};
      end
      RESPOND: cpu_rdata = data_q[q_idx][q_off];
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_q, 2'b00};
        mem_wdata = wdata_q;
        cpu_stall = !mem_ready;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;
  logic        clock, reset;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  dcache_ctrl #(.INDEX_BITS(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Backing memory: written words remembered, others follow a fixed pattern
  logic [31:0] bmem [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (bmem.exists(k)) return bmem[k];
    return k ^ 32'h1234_5678;
  endfunction

  // Cache model: which line holds which tag. With write-through, a valid
  // line's contents always equal backing memory.
  bit          mvalid [16];
  logic [23:0] mtag   [16];
  function automatic bit model_hit(input logic [31:0] a);
    return mvalid[a[7:4]] && (mtag[a[7:4]] == a[31:8]);
  endfunction
  task automatic model_fill(input logic [31:0] a);
    mvalid[a[7:4]] = 1'b1;
    mtag[a[7:4]]   = a[31:8];
  endtask
  task automatic model_clear();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  // Memory responder: ready after lat_cfg cycles of mem_req per word
  int          lat_cfg = 1;
  bit          resp_en = 1'b1;
  logic        r_ready = 1'b0, man_ready = 1'b0;
  logic [31:0] r_rdata = '0, man_rdata = '0;
  int          wcnt = 0;
  assign mem_ready = resp_en ? r_ready : man_ready;
  assign mem_rdata = resp_en ? r_rdata : man_rdata;

  always @(posedge clock) begin
    #1;
    if (mem_req && !reset) begin
      wcnt++;
      if (wcnt >= lat_cfg) begin
        r_ready = 1'b1;
        r_rdata = mem_we ? 32'h0 : mem_rd(mem_addr);
        wcnt    = 0;
      end else begin
        r_ready = 1'b0;
      end
    end else begin
      r_ready = 1'b0;
      wcnt    = 0;
    end
  end

  // Per-cycle comparison against the model
  bit          cmp_en = 1'b0;
  int          rk = 0;
  logic [31:0] refill_log [$];
  always @(negedge clock) begin
    if (!cmp_en || reset) begin
      rk = 0;
    end else begin
      if (cpu_read && !cpu_write && !cpu_stall)
        chk("cmp_rdata", cpu_rdata, mem_rd(cpu_addr));
      if (!cpu_read && !cpu_write) begin
        chk("cmp_idle_stall", {31'd0, cpu_stall}, 32'd0);
        chk("cmp_idle_req", {31'd0, mem_req}, 32'd0);
      end
      if (mem_req && mem_we) begin
        chk("cmp_wr_addr", mem_addr, {cpu_addr[31:2], 2'b00});
        chk("cmp_wr_data", mem_wdata, cpu_wdata);
      end else if (mem_req) begin
        chk("cmp_refill_cnt", {31'd0, rk < 4}, 32'd1);
        chk("cmp_refill_addr", mem_addr, {cpu_addr[31:4], rk[1:0], 2'b00});
        if (mem_ready) begin
          refill_log.push_back(mem_addr);
          rk++;
        end
      end
      if (!mem_req || mem_we) rk = 0;
    end
  end

  // Drivers: start and end just after a rising edge
  task automatic rd(input logic [31:0] a, input int lat, output int stalls, output bit hit);
    int n;
    hit = model_hit(a);
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = a; lat_cfg = lat;
    refill_log.delete();
    stalls = 0; n = 0;
    @(negedge clock);
    while (cpu_stall && n < 300) begin
      stalls++; n++;
      @(negedge clock);
    end
    if (cpu_stall) chk("rd_timeout", 32'd1, 32'd0);
    chk("rd_data", cpu_rdata, mem_rd(a));
    chk("rd_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rd_stalls", stalls, hit ? 32'd0 : 32'(1 + 4 * lat));
    @(posedge clock); #1;
    cpu_read = 1'b0;
    if (!hit) model_fill(a);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int lat, input bit both,
                    output int stalls, output int we_cyc);
    int n, exp_st;
    bit hit;
    hit = model_hit(a);
    cpu_read = both; cpu_write = 1'b1; cpu_addr = a; cpu_wdata = d; lat_cfg = lat;
    stalls = 0; we_cyc = 0; n = 0;
    @(negedge clock);
    while (1) begin
      if (mem_req && mem_we) we_cyc++;
      if (!cpu_stall || n >= 300) break;
      stalls++; n++;
      @(negedge clock);
    end
    if (cpu_stall) chk("wr_timeout", 32'd1, 32'd0);
    exp_st = lat;
`ifdef DCACHE_WRITE_ALLOCATE_EN
    if (!hit) exp_st = 1 + 4 * lat + (lat - 1);
`endif
    chk("wr_stalls", stalls, exp_st);
    chk("wr_we_cycles", we_cyc, lat);
    @(posedge clock); #1;
    cpu_write = 1'b0; cpu_read = 1'b0;
    bmem[{a[31:2], 2'b00}] = d;
`ifdef DCACHE_WRITE_ALLOCATE_EN
    if (!hit) model_fill(a);
`endif
  endtask

  typedef struct { logic [31:0] a; int lat; bit hit; } vec_t;
  vec_t vt [7];

  initial begin
    int st, wc;
    bit h;
    reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    model_clear();
    for (int i = 0; i < 4; i++) bmem[32'h40 + 32'(4 * i)] = 32'hA0 + 32'(i);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    @(posedge clock); #1;
    cmp_en = 1'b1;

    // Cold read miss with 2-cycle memory latency
    rd(32'h40, 2, st, h);
    chk("r036_hit", {31'd0, h}, 32'd0);
    chk("r036_stalls", st, 32'd9);
    chk("r036_nwords", refill_log.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("r036_refill_addr", (i < refill_log.size()) ? refill_log[i] : 32'hFFFF_FFFF,
          32'h40 + 32'(4 * i));
    chk("r036_data_lit", mem_rd(32'h40), 32'hA0);

    // Hit on the same line
    rd(32'h48, 1, st, h);
    chk("r037_hit", {31'd0, h}, 32'd1);
    chk("r037_stalls", st, 32'd0);
    chk("r037_data_lit", mem_rd(32'h48), 32'hA2);

    // Write hit, then read it back
    wr(32'h44, 32'hDEAD_BEEF, 2, 1'b0, st, wc);
    chk("r038_stalls", st, 32'd2);
    chk("r038_we_cycles", wc, 32'd2);
    rd(32'h44, 1, st, h);
    chk("r038_rd_hit", {31'd0, h}, 32'd1);
    chk("r038_rd_stalls", st, 32'd0);
    chk("r038_rd_lit", mem_rd(32'h44), 32'hDEAD_BEEF);

    // Conflict on the same index evicts the line
    rd(32'h140, 2, st, h);
    chk("r039_stalls", st, 32'd9);
    rd(32'h40, 1, st, h);
    chk("r039_remiss_stalls", st, 32'd5);

    // Write miss
    wr(32'h200, 32'h1234_5678, 3, 1'b0, st, wc);
    rd(32'h200, 1, st, h);
`ifdef DCACHE_WRITE_ALLOCATE_EN
    chk("r040_rd_stalls", st, 32'd0);
`else
    chk("r040_rd_stalls", st, 32'd5);
`endif
    chk("r040_rd_lit", mem_rd(32'h200), 32'h1234_5678);

    // Read and write together behave as a write
    wr(32'h48, 32'hCAFE_F00D, 1, 1'b1, st, wc);
    chk("both_stalls", st, 32'd1);
    rd(32'h48, 2, st, h);
    chk("both_rd_stalls", st, 32'd0);
    chk("both_rd_lit", mem_rd(32'h48), 32'hCAFE_F00D);

    // Reset on the 2nd word of a refill, followed by a stray ready
    cmp_en = 1'b0; resp_en = 1'b0; man_ready = 1'b0;
    cpu_read = 1'b1; cpu_addr = 32'h300;
    @(posedge clock); #1;
    man_ready = 1'b1; man_rdata = 32'h11;
    @(posedge clock); #1;
    man_rdata = 32'h22; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; cpu_read = 1'b0; man_rdata = 32'h33;
    @(negedge clock);
    chk("r041_mem_req", {31'd0, mem_req}, 32'd0);
    chk("r041_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clock); #1;
    man_ready = 1'b0;
    @(negedge clock);
    chk("r041_mem_req2", {31'd0, mem_req}, 32'd0);
    @(posedge clock); #1;
    model_clear();
    resp_en = 1'b1; cmp_en = 1'b1;

    // Directed vectors from an empty cache
    vt[0] = '{32'h300,  1, 1'b0};
    vt[1] = '{32'h304,  2, 1'b1};
    vt[2] = '{32'h30C,  1, 1'b1};
    vt[3] = '{32'h1300, 2, 1'b0};
    vt[4] = '{32'h308,  3, 1'b0};
    vt[5] = '{32'h50,   1, 1'b0};
    vt[6] = '{32'h5C,   2, 1'b1};
    for (int i = 0; i < 7; i++) begin
      rd(vt[i].a, vt[i].lat, st, h);
      chk("vec_hit", {31'd0, h}, {31'd0, vt[i].hit});
    end
    chk("vec_304_lit", mem_rd(32'h304), 32'h1234_557C);

    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
